sci_uart_tx: RTL and testbench
==============================

// Module: sci_uart_tx
// PURPOSE
//   Byte-wide UART transmitter that sits directly downstream of the SCI frame controller.
//   It consumes tx_data/tx_start, paced by the tx_ready handshake, and serialises each byte onto txd.
//   Frame format: 1 start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
//   All timing is derived from clk by an integer baud divider.
// PARAMETERS
//   CLK_HZ     50_000_000  system clock frequency in Hz
//   BAUD       115_200     line rate in bit/s
//   PARITY     0           0 = none, 1 = odd, 2 = even
//   STOP_BITS  1           1 or 2 stop bits
//   DIV (localparam)       (CLK_HZ + BAUD/2) / BAUD, clocks per bit; DIV < 2 is illegal (simulation $error)
// PORTS
//   clk       in   1  system clock
//   rst_n     in   1  asynchronous reset, active-low
//   tx_start  in   1  send request, level-sensitive, sampled only while tx_ready = 1
//   tx_data   in   8  byte to send, captured on the accepting edge
//   tx_ready  out  1  1 = idle and able to accept a byte; 0 = frame in progress
//   txd       out  1  serial line output, idle high
//   tx_done   out  1  one-clk pulse when the last stop bit completes
// BEHAVIOUR
//   Reset and clocking:
//   - rst_n, asynchronous, active-low; clock clk; all outputs registered.
//   - Reset values: txd = 1, tx_ready = 1, tx_done = 0, state = IDLE, counters = 0, shift reg = 0.
//   States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   - IDLE: on an edge with tx_start = 1, latch tx_data into shift reg and compute parity bit
//     (odd: ~^tx_data; even: ^tx_data). On that same edge: txd <= 0, tx_ready <= 0,
//     baud_cnt <= 0, go to START.
//   - Every non-IDLE state holds its txd value for exactly DIV clks. baud_cnt counts 0..DIV-1;
//     the state/bit advances on the edge where baud_cnt = DIV-1.
//   - DATA: txd = shift reg[0]; shift right once per bit; bit_cnt 0..7; leave after bit 7.
//   - PARITY: entered only if PARITY != 0; txd = latched parity bit; lasts one bit time.
//   - STOP: txd = 1 for STOP_BITS * DIV clks. On the final edge: tx_ready <= 1,
//     tx_done <= 1 for 1 clk, go to IDLE.
//   Timing:
//   - Frame length = DIV * (10 + (PARITY != 0) + (STOP_BITS - 1)) clks, from the accepting edge
//     to the tx_ready rising edge.
//   - Back-to-back: if tx_start = 1 in the first IDLE cycle, the next start bit begins on that edge.
//     The minimum inter-frame gap is one clk of stop level beyond the nominal stop time.
//   Handshake:
//   - tx_ready falls on the accepting edge and stays low for the whole frame (>= 10*DIV clks).
//     This lets the upstream controller see tx_ready = 0 and drop tx_start before the frame ends,
//     so a held request never sends a byte twice.
//   Boundary cases:
//   - tx_start or tx_data changes while tx_ready = 0: ignored. The latched byte is sent unchanged.
//   - tx_start already high coming out of reset: accepted on the first clk edge after rst_n deasserts.
//   - Reset mid-frame: txd returns to 1 and tx_ready to 1 immediately (asynchronous). The frame is
//     abandoned and no tx_done is issued.
//   - Counter widths: baud_cnt is $clog2(DIV) bits and never exceeds DIV-1; bit_cnt is 3 bits;
//     a stop-bit counter handles STOP_BITS = 2.
// TESTING  (CLK_HZ = 16, BAUD = 1 -> DIV = 16 unless noted)
//   1. PARITY=0, send 0x55 -> txd = 0,1,0,1,0,1,0,1,0,1, each bit 16 clks; tx_ready low 160 clks;
//      tx_done high exactly 1 clk at cycle 160.
//   2. PARITY=2, send 0x07 -> parity bit 1, frame 176 clks. PARITY=1, send 0x07 -> parity bit 0.
//   3. Controller-style handshake: 4 bytes 0xA1,0xB2,0xC3,0xD4 with tx_start held until tx_ready = 0
//      -> 4 frames, each byte sent exactly once in order, decoded correctly by the bench receiver.
//   4. Pulse tx_start with tx_data = 0xFF at cycle 40 of a 0x00 frame -> ignored; only 0x00 is sent.
//   5. Assert rst_n low at cycle 70 of a frame -> txd = 1 and tx_ready = 1 in the same cycle,
//      no tx_done; after release, sending 0x3C gives a clean frame.
//   6. STOP_BITS=2, send 0x80 -> stop level 32 clks, frame 176 clks; a held tx_start starts the
//      next frame one clk after tx_done.

Source files
------------

// File: rtl/sci_uart_tx.sv
// -----------------------------------------------------------------------------
// sci_uart_tx
// Byte-wide UART transmitter fed by the SCI frame controller. A byte offered
// on tx_data/tx_start while tx_ready is high is captured and serialised on txd
// as: 1 start bit, 8 data bits LSB first, an optional parity bit, then 1 or 2
// stop bits. Each bit lasts DIV clocks, with DIV derived from CLK_HZ / BAUD.
//
// Parameters
//   CLK_HZ    system clock frequency in Hz
//   BAUD      line rate in bit/s
//   PARITY    0 = none, 1 = odd, 2 = even
//   STOP_BITS 1 or 2
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous reset, active-low
//   tx_start  in   send request, level-sensitive, only looked at while idle
//   tx_data   in   [7:0] byte to send, captured on the accepting edge
//   tx_ready  out  1 = idle and able to accept a byte
//   txd       out  serial line, idle high
//   tx_done   out  one-clock pulse when the last stop bit completes
// -----------------------------------------------------------------------------
module sci_uart_tx #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int BAUD      = 115_200,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       txd,
   output logic       tx_done
);

   localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

   localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(DIV - 1);
   localparam logic             STOP_LAST  = (STOP_BITS == 2) ? 1'b1 : 1'b0;
   localparam logic             HAS_PARITY = (PARITY != 0) ? 1'b1 : 1'b0;

   // Parameter sanity: a divider below 2 cannot produce a usable bit time.
   if (DIV < 2) begin : g_div_check
      $error("sci_uart_tx: DIV = %0d is illegal (must be >= 2)", DIV);
   end
   if ((PARITY < 0) || (PARITY > 2)) begin : g_parity_check
      $error("sci_uart_tx: PARITY = %0d is illegal (0, 1 or 2)", PARITY);
   end
   if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_stop_check
      $error("sci_uart_tx: STOP_BITS = %0d is illegal (1 or 2)", STOP_BITS);
   end

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   // Parity bit for the configured mode: odd makes the total count of ones
   // (data + parity) odd, even makes it even.
   function automatic logic parity_bit(input logic [7:0] data);
      logic p;
      if (PARITY == 1) begin
         p = ~^data;
      end else begin
         p = ^data;
      end
      return p;
   endfunction

   state_t           state_q,    state_d;
   logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]       bit_cnt_q,  bit_cnt_d;
   logic             stop_cnt_q, stop_cnt_d;
   logic [7:0]       shift_q,    shift_d;
   logic             parity_q,   parity_d;
   logic             txd_q,      txd_d;
   logic             tx_ready_q, tx_ready_d;
   logic             tx_done_q,  tx_done_d;

   logic             bit_end_s;

   // Last clock of the current bit time.
   assign bit_end_s = (baud_cnt_q == BAUD_LAST) ? 1'b1 : 1'b0;

   // State register; reset drives the line idle and the interface ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= 3'd0;
         stop_cnt_q <= 1'b0;
         shift_q    <= 8'h00;
         parity_q   <= 1'b0;
         txd_q      <= 1'b1;
         tx_ready_q <= 1'b1;
         tx_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         shift_q    <= shift_d;
         parity_q   <= parity_d;
         txd_q      <= txd_d;
         tx_ready_q <= tx_ready_d;
         tx_done_q  <= tx_done_d;
      end
   end

   // Next-state logic. txd_d always carries the level for the bit that starts
   // on the coming edge, so the line output stays a plain flop.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      shift_d    = shift_q;
      parity_d   = parity_q;
      txd_d      = txd_q;
      tx_ready_d = tx_ready_q;
      tx_done_d  = 1'b0;

      if (state_q == ST_IDLE) begin
         baud_cnt_d = '0;
      end else if (bit_end_s) begin
         baud_cnt_d = '0;
      end else begin
         baud_cnt_d = baud_cnt_q + CNT_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            txd_d      = 1'b1;
            tx_ready_d = 1'b1;
            if (tx_start) begin
               shift_d    = tx_data;
               parity_d   = parity_bit(tx_data);
               txd_d      = 1'b0;
               tx_ready_d = 1'b0;
               state_d    = ST_START;
            end else begin
               state_d    = ST_IDLE;
            end
         end

         ST_START: begin
            if (bit_end_s) begin
               txd_d     = shift_q[0];
               bit_cnt_d = 3'd0;
               state_d   = ST_DATA;
            end else begin
               state_d   = ST_START;
            end
         end

         ST_DATA: begin
            if (bit_end_s && (bit_cnt_q == 3'd7)) begin
               if (HAS_PARITY) begin
                  txd_d   = parity_q;
                  state_d = ST_PARITY;
               end else begin
                  txd_d      = 1'b1;
                  stop_cnt_d = 1'b0;
                  state_d    = ST_STOP;
               end
            end else if (bit_end_s) begin
               // shift_q[1] becomes the new LSB after this shift.
               txd_d     = shift_q[1];
               shift_d   = {1'b0, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
            end else begin
               state_d   = ST_DATA;
            end
         end

         ST_PARITY: begin
            if (bit_end_s) begin
               txd_d      = 1'b1;
               stop_cnt_d = 1'b0;
               state_d    = ST_STOP;
            end else begin
               state_d    = ST_PARITY;
            end
         end

         ST_STOP: begin
            if (bit_end_s && (stop_cnt_q == STOP_LAST)) begin
               txd_d      = 1'b1;
               tx_ready_d = 1'b1;
               tx_done_d  = 1'b1;
               state_d    = ST_IDLE;
            end else if (bit_end_s) begin
               stop_cnt_d = 1'b1;
            end else begin
               state_d    = ST_STOP;
            end
         end

         default: begin
            // Unreachable encodings recover to a clean idle line.
            state_d    = ST_IDLE;
            baud_cnt_d = '0;
            txd_d      = 1'b1;
            tx_ready_d = 1'b1;
         end
      endcase
   end

   assign tx_ready = tx_ready_q;
   assign txd      = txd_q;
   assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_sci_uart_tx.sv
// Self-checking bench for sci_uart_tx. Four instances cover the parity and
// stop-bit options; expected line levels come from a frame-level model that
// indexes the ideal bit sequence by elapsed clocks.
module tb_sci_uart_tx;

   localparam int CLK_HZ = 16;
   localparam int BAUD   = 1;
   localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int NU     = 4;

   localparam int M_NORM   = 0;
   localparam int M_HOLD   = 1;
   localparam int M_GLITCH = 2;
   localparam int M_RST    = 3;

   // per-instance configuration: parity mode and stop bits
   int par_tab [NU] = '{0, 2, 1, 0};
   int stp_tab [NU] = '{1, 1, 1, 2};

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NU-1:0] start_s;
   logic [NU-1:0] ready_s;
   logic [NU-1:0] txd_s;
   logic [NU-1:0] done_s;
   logic [7:0]    data_s [NU];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sci_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY(0), .STOP_BITS(1)) u0 (
      .clk(clk), .rst_n(rst_n), .tx_start(start_s[0]), .tx_data(data_s[0]),
      .tx_ready(ready_s[0]), .txd(txd_s[0]), .tx_done(done_s[0]));
   sci_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY(2), .STOP_BITS(1)) u1 (
      .clk(clk), .rst_n(rst_n), .tx_start(start_s[1]), .tx_data(data_s[1]),
      .tx_ready(ready_s[1]), .txd(txd_s[1]), .tx_done(done_s[1]));
   sci_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY(1), .STOP_BITS(1)) u2 (
      .clk(clk), .rst_n(rst_n), .tx_start(start_s[2]), .tx_data(data_s[2]),
      .tx_ready(ready_s[2]), .txd(txd_s[2]), .tx_done(done_s[2]));
   sci_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY(0), .STOP_BITS(2)) u3 (
      .clk(clk), .rst_n(rst_n), .tx_start(start_s[3]), .tx_data(data_s[3]),
      .tx_ready(ready_s[3]), .txd(txd_s[3]), .tx_done(done_s[3]));

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int frame_len(input int u);
      return DIV * (10 + ((par_tab[u] != 0) ? 1 : 0) + (stp_tab[u] - 1));
   endfunction

   // Ideal line level k clocks after the accepting edge.
   function automatic logic exp_bit(input int u, input logic [7:0] b, input int k);
      int idx;
      int ones;
      idx  = k / DIV;
      ones = $countones(b);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if ((par_tab[u] != 0) && (idx == 9)) begin
         if (par_tab[u] == 2) return ((ones % 2) == 1);
         return ((ones % 2) == 0);
      end
      return 1'b1;
   endfunction

   // Follows one frame from just after its accepting edge. Ends on the
   // negedge after the final stop edge, where tx_done must be high.
   task automatic run_frame(input int u, input logic [7:0] b, input int mode, input int evt_k);
      int         len;
      logic [7:0] rx;
      len = frame_len(u);
      rx  = 8'h00;
      for (int k = 0; k < len; k++) begin
         @(negedge clk);
         check_eq("txd_bit",   txd_s[u],   exp_bit(u, b, k));
         check_eq("ready_low", ready_s[u], 1'b0);
         check_eq("done_low",  done_s[u],  1'b0);
         // mid-bit sampling receiver
         if (((k % DIV) == DIV / 2) && (k / DIV >= 1) && (k / DIV <= 8))
            rx[k / DIV - 1] = txd_s[u];
         if ((k == 0) && (mode != M_HOLD)) start_s[u] = 1'b0;
         if ((mode == M_GLITCH) && (k == evt_k)) begin
            start_s[u] = 1'b1;
            data_s[u]  = 8'hFF;
         end
         if ((mode == M_GLITCH) && (k == evt_k + 1)) start_s[u] = 1'b0;
         if ((mode == M_RST) && (k == evt_k)) begin
            rst_n = 1'b0;
            #1;
            check_eq("rst_txd_now",   txd_s[u],   1'b1);
            check_eq("rst_ready_now", ready_s[u], 1'b1);
            check_eq("rst_done_now",  done_s[u],  1'b0);
            repeat (4) begin
               @(negedge clk);
               check_eq("rst_no_done", done_s[u],  1'b0);
               check_eq("rst_ready",   ready_s[u], 1'b1);
               check_eq("rst_txd",     txd_s[u],   1'b1);
            end
            rst_n = 1'b1;
            return;
         end
      end
      check_eq("rx_byte", rx, b);
      @(negedge clk);
      check_eq("end_ready", ready_s[u], 1'b1);
      check_eq("end_done",  done_s[u],  1'b1);
      check_eq("end_txd",   txd_s[u],   1'b1);
   endtask

   // Called on a negedge with the instance idle.
   task automatic send(input int u, input logic [7:0] b, input int mode, input int evt_k);
      check_eq("ready_idle", ready_s[u], 1'b1);
      start_s[u] = 1'b1;
      data_s[u]  = b;
      @(posedge clk);
      run_frame(u, b, mode, evt_k);
   endtask

   logic [7:0] seq [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

   initial begin
      int         u;
      logic [7:0] b;
      rst_n   = 1'b0;
      start_s = '0;
      for (int i = 0; i < NU; i++) data_s[i] = 8'h00;
      // request already pending while reset is held
      start_s[0] = 1'b1;
      data_s[0]  = 8'hC5;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NU; i++) begin
         check_eq("reset_txd",   txd_s[i],   1'b1);
         check_eq("reset_ready", ready_s[i], 1'b1);
         check_eq("reset_done",  done_s[i],  1'b0);
      end
      rst_n = 1'b1;
      @(posedge clk);
      run_frame(0, 8'hC5, M_NORM, 0);

      // basic frame, no parity
      send(0, 8'h55, M_NORM, 0);
      // even and odd parity
      send(1, 8'h07, M_NORM, 0);
      send(2, 8'h07, M_NORM, 0);
      // controller-style back-to-back stream
      for (int i = 0; i < 4; i++) send(0, seq[i], M_NORM, 0);
      // request during a frame is ignored
      send(0, 8'h00, M_GLITCH, 40);
      // reset mid-frame, then a clean frame
      send(0, 8'hA5, M_RST, 70);
      send(0, 8'h3C, M_NORM, 0);
      // two stop bits, held request restarts one clock after tx_done
      send(3, 8'h80, M_HOLD, 0);
      data_s[3] = 8'h81;
      @(posedge clk);
      run_frame(3, 8'h81, M_NORM, 0);

      // random traffic on random instances
      repeat (8) begin
         u = $urandom_range(0, NU - 1);
         b = 8'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(u, b, M_NORM, 0);
      end

      @(negedge clk);
      for (int i = 0; i < NU; i++) begin
         check_eq("final_done",  done_s[i],  1'b0);
         check_eq("final_ready", ready_s[i], 1'b1);
         check_eq("final_txd",   txd_s[i],   1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
